// File: rtl/alu_mul_seq.sv
// 6x6 unsigned shift-add multiplier that drives an external 6-bit ALU for its adds.
// One add-and-shift per clock for six clocks, with a start/done handshake.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  multiplicand,
  input  logic [5:0]  multiplier,
  output logic [11:0] product,
  output logic        busy,
  output logic        done,
  output logic [5:0]  alu_a,
  output logic [5:0]  alu_b,
  output logic        alu_carry_in,
  output logic [3:0]  alu_op,
  input  logic [5:0]  alu_result,
  input  logic        alu_carry_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, next_state;
  logic [5:0]  m_reg;
  logic [5:0]  acc_hi;
  logic [5:0]  acc_lo;
  logic [2:0]  cnt;
  logic        load;
  logic        step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A start is only honoured when no multiply is in flight.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == 3'd5) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The ALU carry shifts into acc_hi[5], so the 13-bit {carry,sum,lo} shift loses nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg  <= 6'd0;
      acc_hi <= 6'd0;
      acc_lo <= 6'd0;
      cnt    <= 3'd0;
    end else if (load) begin
      m_reg  <= multiplicand;
      acc_hi <= 6'd0;
      acc_lo <= multiplier;
      cnt    <= 3'd0;
    end else if (step) begin
      acc_hi <= {alu_carry_out, alu_result[5:1]};
      acc_lo <= {alu_result[0], acc_lo[5:1]};
      cnt    <= cnt + 3'd1;
    end
  end

  assign product      = {acc_hi, acc_lo};
  assign busy         = (state == CALC);
  assign done         = (state == DONE);
  assign alu_a        = acc_hi;
  assign alu_b        = acc_lo[0] ? m_reg : 6'd0;
  assign alu_carry_in = 1'b0;
  assign alu_op       = 4'b0010;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural 6-bit ALU, directed multiplies, and a
// scoreboard queue whose entries are popped by a monitor on every done pulse.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  multiplicand;
  logic [5:0]  multiplier;
  logic [11:0] product;
  logic        busy;
  logic        done;
  logic [5:0]  alu_a;
  logic [5:0]  alu_b;
  logic        alu_carry_in;
  logic [3:0]  alu_op;
  logic [5:0]  alu_result;
  logic        alu_carry_out;

  int errors = 0;
  int checks = 0;
  logic [11:0] sb[$];
  logic        saw_carry = 1'b0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .busy(busy), .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // ALU model: only ADD does an add, anything else gives an unrelated result.
  logic [6:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_carry_in};
    if (alu_op != 4'b0010) alu_sum = {1'b0, alu_a & alu_b};
    alu_result    = alu_sum[5:0];
    alu_carry_out = alu_sum[6];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busy && alu_carry_out) saw_carry <= 1'b1;
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product %0d expected no done", product);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if (product != e) begin
          errors++;
          $display("FAIL product: got %0d expected %0d", product, e);
        end
      end
    end
  end

  // Issue one multiply and follow it through CALC, DONE and the cycle after.
  task automatic do_op(input logic [5:0] m, input logic [5:0] q, input logic [11:0] exp);
    @(posedge clk); #1;
    start = 1'b1; multiplicand = m; multiplier = q;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0; multiplicand = 6'd0; multiplier = 6'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_calc", busy, 1);
      chk("alu_b_calc", alu_b, q[i] ? m : 6'd0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_falls", done, 0);
    chk("product_held", product, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; multiplicand = 6'd0; multiplier = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 2);
    chk("rst_alu_cin", alu_carry_in, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_product", product, 0);
      chk("idle_busy", busy, 0);
    end

    do_op(6'd5, 6'd7, 12'd35);

    saw_carry = 1'b0;
    do_op(6'd63, 6'd63, 12'd3969);
    chk("carry_seen", saw_carry, 1);

    do_op(6'd0, 6'd45, 12'd0);
    do_op(6'd45, 6'd0, 12'd0);
    do_op(6'd13, 6'd1, 12'd13);

    // start mid-CALC is ignored; start during DONE begins the next multiply
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 6'd3; multiplier = 6'd4;
    sb.push_back(12'd12);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; multiplicand = 6'd9; multiplier = 6'd9;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = 6'd0; multiplier = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_prod1", product, 12);
    start = 1'b1; multiplicand = 6'd9; multiplier = 6'd9;
    sb.push_back(12'd81);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_busy", busy, 1);
    end
    @(negedge clk);
    chk("b2b_done2", done, 1);
    chk("b2b_prod2", product, 81);

    // reset after the third CALC edge aborts with no done
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 6'd63; multiplier = 6'd63;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_alu_b", alu_b, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    do_op(6'd2, 6'd3, 12'd6);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
